// File: rtl/oit_event_encoder_pkg.sv
// Shared oitlib helpers for the event encoder slice.
// Holds the width and maximum functions used to size index buses.
package oit_event_encoder_pkg;

  // ceil(log2(n)), never less than one bit so that a bus always exists
  function automatic int oitBits(input int n);
    int b;
    b = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << b) < n) b++;
    end
    return (b < 1) ? 1 : b;
  endfunction

  function automatic int oitMax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/oit_event_encoder_priority.sv
// Combinational lowest-set-bit priority encoder.
// Produces the binary index of the lowest set bit and an any-valid flag.
module oit_priority_encoder
  import oit_event_encoder_pkg::*;
#(
  parameter int  COUNT   = 4,
  localparam int INDEX_W = oitBits(COUNT)
) (
  input  logic [COUNT-1:0]   vec,
  output logic [INDEX_W-1:0] index,
  output logic               valid
);

  // Scan downward so that the lowest set bit is the last one written
  always_comb begin
    index = '0;
    valid = |vec;
    for (int i = COUNT - 1; i >= 0; i--) begin
      if (vec[i]) index = INDEX_W'(i);
    end
  end

endmodule

// File: rtl/oit_event_encoder.sv
// Collects request pulses, holds them pending and reports one binary index per
// event over a valid/ready handshake, with fixed or rotating priority.
module oit_event_encoder
  import oit_event_encoder_pkg::*;
#(
  parameter int  COUNT       = 4,
  parameter bit  ROUND_ROBIN = 1'b0,
  localparam int INDEX_W     = oitMax(1, oitBits(COUNT))
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COUNT-1:0]   req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INDEX_W-1:0] out_index,
  output logic [COUNT-1:0]   pending,
  output logic               busy
);

  logic               take;
  logic               load;
  logic [COUNT-1:0]   avail;
  logic [COUNT-1:0]   mask;
  logic [COUNT-1:0]   pick_oh;
  logic [INDEX_W-1:0] ptr;
  logic [INDEX_W-1:0] u_index;
  logic [INDEX_W-1:0] m_index;
  logic [INDEX_W-1:0] pick;
  logic               u_valid;
  logic               m_valid;

  assign take  = out_valid & out_ready;
  assign load  = ~out_valid | take;
  assign avail = pending | req;
  assign busy  = (|pending) | out_valid;

  // Lines strictly above the last winner; empty mask falls back to a wrap
  always_comb begin
    mask = '0;
    for (int i = 0; i < COUNT; i++) begin
      mask[i] = (INDEX_W'(i) > ptr);
    end
  end

  oit_priority_encoder #(.COUNT(COUNT)) u_enc_all (
    .vec   (avail),
    .index (u_index),
    .valid (u_valid)
  );

  oit_priority_encoder #(.COUNT(COUNT)) u_enc_masked (
    .vec   (avail & mask),
    .index (m_index),
    .valid (m_valid)
  );

  assign pick = (ROUND_ROBIN && m_valid) ? m_index : u_index;

  always_comb begin
    pick_oh = '0;
    for (int i = 0; i < COUNT; i++) begin
      pick_oh[i] = (INDEX_W'(i) == pick);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_index <= '0;
      pending   <= '0;
      ptr       <= INDEX_W'(COUNT - 1);
    end else if (load) begin
      if (u_valid) begin
        out_valid <= 1'b1;
        out_index <= pick;
        pending   <= avail & ~pick_oh;
        if (ROUND_ROBIN) ptr <= pick;
      end else begin
        out_valid <= 1'b0;
        pending   <= '0;
      end
    end else begin
      pending <= avail;
    end
  end

endmodule

// File: tb/tb_oit_event_encoder.sv
// Scoreboard bench for oit_event_encoder: fixed COUNT=4, round-robin COUNT=4 and
// round-robin COUNT=5 instances, one exercised at a time.
module tb_oit_event_encoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       out_ready = 1'b0;
  logic [3:0] req_f = '0;
  logic [3:0] req_r = '0;
  logic [4:0] req_5 = '0;

  logic       valid_f, valid_r, valid_5;
  logic [1:0] index_f, index_r;
  logic [2:0] index_5;
  logic [3:0] pend_f, pend_r;
  logic [4:0] pend_5;
  logic       busy_f, busy_r, busy_5;

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  int exp_q[$];

  always #5 clock = ~clock;

  oit_event_encoder #(.COUNT(4), .ROUND_ROBIN(1'b0)) dut_fix4 (
    .clock(clock), .reset(reset), .req(req_f), .out_valid(valid_f),
    .out_ready(out_ready), .out_index(index_f), .pending(pend_f), .busy(busy_f)
  );

  oit_event_encoder #(.COUNT(4), .ROUND_ROBIN(1'b1)) dut_rr4 (
    .clock(clock), .reset(reset), .req(req_r), .out_valid(valid_r),
    .out_ready(out_ready), .out_index(index_r), .pending(pend_r), .busy(busy_r)
  );

  oit_event_encoder #(.COUNT(5), .ROUND_ROBIN(1'b1)) dut_rr5 (
    .clock(clock), .reset(reset), .req(req_5), .out_valid(valid_5),
    .out_ready(out_ready), .out_index(index_5), .pending(pend_5), .busy(busy_5)
  );

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  // inputs change 1 time unit after the active edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: a handshake seen at negedge is consumed at the next posedge
  always @(negedge clock) begin
    int v;
    int idx;
    int exp_idx;
    v = 0;
    idx = 0;
    case (sel)
      0: begin v = int'(valid_f); idx = int'(index_f); end
      1: begin v = int'(valid_r); idx = int'(index_r); end
      default: begin
        v = int'(valid_5); idx = int'(index_5);
      end
    endcase
    if (!reset && out_ready && v != 0) begin
      if (sel == 2) chk("rr5_range", int'(idx < 5), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", idx, -1);
      end else begin
        exp_idx = exp_q.pop_front();
        chk("event_index", idx, exp_idx);
      end
    end
  end

  initial begin
    // reset state
    step();
    step();
    @(negedge clock);
    chk("rst_valid_f", int'(valid_f), 0);
    chk("rst_index_f", int'(index_f), 0);
    chk("rst_pend_f", int'(pend_f), 0);
    chk("rst_busy_f", int'(busy_f), 0);
    chk("rst_valid_r", int'(valid_r), 0);
    chk("rst_valid_5", int'(valid_5), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step();

    // 1: two-line burst drained back-to-back
    sel = 0;
    exp_q.push_back(1);
    exp_q.push_back(2);
    req_f = 4'b0110;
    out_ready = 1'b1;
    step();
    req_f = 4'b0000;
    @(negedge clock);
    chk("t1_valid", int'(valid_f), 1);
    chk("t1_pending", int'(pend_f), 4'b0100);
    step();
    step();
    @(negedge clock);
    chk("t1_idle", int'(valid_f), 0);
    chk("t1_q_empty", exp_q.size(), 0);

    // 2: stall holds index and pending, then release
    out_ready = 1'b0;
    step();
    exp_q.push_back(0);
    exp_q.push_back(3);
    req_f = 4'b1001;
    step();
    req_f = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t2_hold_valid", int'(valid_f), 1);
      chk("t2_hold_index", int'(index_f), 0);
      chk("t2_hold_pend", int'(pend_f), 4'b1000);
      step();
    end
    out_ready = 1'b1;
    step();
    @(negedge clock);
    chk("t2_second", int'(index_f), 3);
    step();
    @(negedge clock);
    chk("t2_idle_valid", int'(valid_f), 0);
    chk("t2_idle_busy", int'(busy_f), 0);
    chk("t2_q_empty", exp_q.size(), 0);

    // 3a: round robin with all lines requesting every cycle
    sel = 1;
    for (int k = 0; k < 8; k++) exp_q.push_back(k % 4);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    req_r = 4'b1111;
    for (int i = 0; i < 8; i++) step();
    req_r = 4'b0000;
    for (int i = 0; i < 4; i++) step();
    @(negedge clock);
    chk("t3_rr_idle", int'(busy_r), 0);
    chk("t3_rr_q_empty", exp_q.size(), 0);

    // 3b: fixed priority keeps re-arming line 0
    sel = 0;
    for (int k = 0; k < 6; k++) exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    req_f = 4'b1111;
    for (int i = 0; i < 6; i++) step();
    req_f = 4'b0000;
    for (int i = 0; i < 4; i++) step();
    @(negedge clock);
    chk("t3_fix_idle", int'(busy_f), 0);
    chk("t3_fix_q_empty", exp_q.size(), 0);

    // 4: non-power-of-two round robin wraps 4 -> 0
    sel = 2;
    for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 0 : 4);
    exp_q.push_back(0);
    req_5 = 5'b10001;
    for (int i = 0; i < 6; i++) step();
    req_5 = 5'b00000;
    for (int i = 0; i < 3; i++) step();
    @(negedge clock);
    chk("t4_idle", int'(busy_5), 0);
    chk("t4_q_empty", exp_q.size(), 0);

    // 5: re-arm of the held line merges into one pending event
    sel = 0;
    out_ready = 1'b0;
    exp_q.push_back(2);
    exp_q.push_back(2);
    req_f = 4'b0100;
    step();
    @(negedge clock);
    chk("t5_held", int'(index_f), 2);
    chk("t5_pend0", int'(pend_f), 0);
    step();
    step();
    req_f = 4'b0000;
    @(negedge clock);
    chk("t5_merged", int'(pend_f), 4'b0100);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    @(negedge clock);
    chk("t5_idle", int'(busy_f), 0);
    chk("t5_q_empty", exp_q.size(), 0);

    // 6: reset mid-operation discards held, pending and incoming events
    out_ready = 1'b0;
    req_f = 4'b1111;
    step();
    req_f = 4'b0000;
    @(negedge clock);
    chk("t6_pre_valid", int'(valid_f), 1);
    chk("t6_pre_pend", int'(pend_f), 4'b1110);
    step();
    reset = 1'b1;
    req_f = 4'b0001;
    step();
    reset = 1'b0;
    req_f = 4'b0000;
    @(negedge clock);
    chk("t6_valid", int'(valid_f), 0);
    chk("t6_index", int'(index_f), 0);
    chk("t6_pend", int'(pend_f), 0);
    chk("t6_busy", int'(busy_f), 0);
    out_ready = 1'b1;
    step();
    step();
    @(negedge clock);
    chk("t6_no_report", int'(valid_f), 0);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
